tm_arbiter: RTL and testbench
=============================

Name: tm_arbiter

Overview:
- Shares the single-port 64 KiB test memory between the 6502 core (CPU port) and a DMA/debug loader port.
- CPU has priority. Idle CPU cycles go to DMA. A starvation counter forces a bounded DMA burst, during which the CPU is stalled via RDY.
- Sits directly between the core, the loader and the test memory. Drives the memory's address, read/write-complement, write-data and read-data pins.

Parameters:
- MAX_WAIT, 8: cycles a pending DMA request may be denied before a forced burst; legal range 1..255.
- BURST, 4: maximum consecutive DMA grants in a forced burst; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU wants a memory cycle this clock.
- cpu_addr  in  16  CPU address.
- cpu_rW  in  1  CPU read/write-complement (0 = write).
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data to CPU; combinational from memory.
- cpu_rdy  out  1  CPU may proceed this cycle; 0 = stall.
- dma_req  in  1  DMA request; held until dma_gnt.
- dma_addr  in  16  DMA address.
- dma_rW  in  1  DMA read/write-complement.
- dma_wdata  in  8  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rdata  out  8  registered DMA read data.
- dma_rvalid  out  1  one-cycle pulse, cycle after a granted DMA read.
- tm_address  out  16  memory address.
- tm_rW  out  1  memory read/write-complement.
- tm_indata  out  8  memory write data.
- tm_data  in  8  memory read data (combinational).

Behaviour:
- State register with two states, CPU_MODE and DMA_MODE. Reset state is CPU_MODE.
- Counters:
  - wait_cnt: 8 bits, saturating.
  - burst_cnt: 8 bits.
  - Both reset to 0.
- Registered output reset values: dma_rdata = 0x00, dma_rvalid = 0.
- While rst_n is low, tm_rW = 1 (no writes), dma_gnt = 0 and cpu_rdy = 0.
- Grant logic is combinational from state and the current requests:
  - CPU_MODE: if cpu_req, the CPU is granted and cpu_rdy = 1. Else if dma_req, DMA is granted (idle-slot fill) and cpu_rdy = 1. Else nothing is granted and cpu_rdy = 1.
  - DMA_MODE: cpu_rdy = 0. DMA is granted if dma_req.
- Memory mux:
  - Granted requester drives tm_address, tm_rW and tm_indata.
  - With no grant: CPU address, tm_rW forced to 1, tm_indata = cpu_wdata.
  - cpu_rdata = tm_data at all times.
- The memory writes on the rising edge when tm_rW = 0, so a granted write completes at the end of the grant cycle.
- DMA read response: on a granted DMA read, dma_rdata <= tm_data and dma_rvalid <= 1 at that edge. Otherwise dma_rvalid <= 0.
- wait_cnt:
  - Cleared when dma_req = 0 or dma_gnt = 1.
  - Otherwise increments, saturating at 255.
- CPU_MODE -> DMA_MODE when dma_req = 1, dma_gnt = 0 and wait_cnt == MAX_WAIT-1 in the same cycle. burst_cnt is cleared on entry.
- DMA_MODE:
  - burst_cnt increments on each dma_gnt.
  - Returns to CPU_MODE when dma_req = 0, or when a grant occurs with burst_cnt == BURST-1.
  - The exit is taken at that clock edge, so the CPU resumes on the next cycle.
  - On exit, wait_cnt is 0, so a continuously asserted dma_req is not re-forced for MAX_WAIT further cycles.
- Simultaneous cpu_req and dma_req in CPU_MODE below threshold: CPU wins, DMA waits.
- A DMA write followed by a DMA read to the same address in the next grant returns the written data.
- Reset asserted mid-burst: immediate return to CPU_MODE, counters and dma_rvalid clear, and any in-flight grant is abandoned with no write.

Test Plan:
- CPU only, cpu_req = 1 for 20 cycles, reading 0x1234 preloaded with 0x5A -> cpu_rdata = 0x5A the same cycle, cpu_rdy = 1 throughout, dma_gnt = 0.
- cpu_req = 0, DMA writes 0xAB to 0x0200 then reads 0x0200 -> dma_gnt = 1 in each request cycle, tm_rW = 0 only in the write cycle, dma_rvalid pulses one cycle after the read with dma_rdata = 0xAB.
- MAX_WAIT = 8, BURST = 4, cpu_req and dma_req held high from cycle 0 -> first dma_gnt at cycle 8, cpu_rdy = 0 for cycles 8–11, CPU granted at cycle 12, next burst at cycle 20 (12-cycle period).
- Forced burst where dma_req drops after 2 grants -> DMA_MODE exits at that edge, cpu_rdy = 1 on the next cycle, burst_cnt and wait_cnt = 0.
- rst_n pulsed low during the 2nd cycle of a DMA_MODE write burst -> tm_rW = 1 and cpu_rdy = 0 immediately, target byte unchanged, state CPU_MODE and dma_rvalid = 0 after release.

Source files
------------

// File: rtl/tm_arbiter.sv
// Arbitrates the single-port test memory between the 6502 core and a DMA/debug loader.
// Grants are combinational (zero latency); DMA read data returns one cycle after its grant; CPU stalls via cpu_rdy during forced bursts.
module tm_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int BURST    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rW,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_rW,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] tm_address,
    output logic        tm_rW,
    output logic [7:0]  tm_indata,
    input  logic [7:0]  tm_data
);

    typedef enum logic {CPU_MODE, DMA_MODE} state_e;

    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [7:0]  dma_rdata_q;
    logic        dma_rvalid_q;
    logic        cpu_gnt;

    // Gating on rst_n keeps the memory from seeing a write while reset is held.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        cpu_rdy = 1'b0;
        if (rst_n) begin
            if (state_q == CPU_MODE) begin
                cpu_rdy = 1'b1;
                cpu_gnt = cpu_req;
                dma_gnt = !cpu_req && dma_req;
            end else begin
                dma_gnt = dma_req;
            end
        end
    end

    always_comb begin
        tm_address = cpu_addr;
        tm_rW      = 1'b1;
        tm_indata  = cpu_wdata;
        if (dma_gnt) begin
            tm_address = dma_addr;
            tm_rW      = dma_rW;
            tm_indata  = dma_wdata;
        end else if (cpu_gnt) begin
            tm_rW      = cpu_rW;
        end
    end

    assign cpu_rdata  = tm_data;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (!dma_req || dma_gnt) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == 8'hFF) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        case (state_q)
            CPU_MODE: begin
                if (dma_req && !dma_gnt && wait_cnt_q == WAIT_LAST) begin
                    state_d     = DMA_MODE;
                    burst_cnt_d = 8'd0;
                end
            end
            DMA_MODE: begin
                if (dma_gnt) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                // Leaving clears the burst count so the next entry starts fresh.
                if (!dma_req || (dma_gnt && burst_cnt_q == BURST_LAST)) begin
                    state_d     = CPU_MODE;
                    burst_cnt_d = 8'd0;
                end
            end
            default: state_d = CPU_MODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CPU_MODE;
            wait_cnt_q   <= 8'd0;
            burst_cnt_q  <= 8'd0;
            dma_rdata_q  <= 8'h00;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            dma_rvalid_q <= dma_gnt && dma_rW;
            if (dma_gnt && dma_rW) begin
                dma_rdata_q <= tm_data;
            end
        end
    end

endmodule

// File: tb/tb_tm_arbiter.sv
// Randomized and directed checks of tm_arbiter against a countdown-style burst model and a shadow memory.
module tb_tm_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int BURST    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic        cpu_rW = 1'b1;
    logic [7:0]  cpu_wdata = 8'h0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = 16'h0;
    logic        dma_rW = 1'b1;
    logic [7:0]  dma_wdata = 8'h0;
    logic        dma_gnt;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic [15:0] tm_address;
    logic        tm_rW;
    logic [7:0]  tm_indata;
    logic [7:0]  tm_data;

    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_dat = 8'h0;
    logic [7:0]  ram    [0:65535];
    logic [7:0]  shadow [0:65535];

    int total = 0;
    int bad = 0;

    bit       in_burst = 1'b0;
    int       burst_left = 0;
    int       denied = 0;
    bit       exp_rvalid = 1'b0;
    logic [7:0] exp_rdata = 8'h00;
    bit       last_dgnt = 1'b0;
    logic     obs_gnt, obs_rdy, obs_rw, obs_rv;
    logic [7:0] obs_rd, obs_cpud;

    tm_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rW(cpu_rW), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rW(dma_rW), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .tm_address(tm_address), .tm_rW(tm_rW), .tm_indata(tm_indata), .tm_data(tm_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_dat;
        else if (!tm_rW) ram[tm_address] <= tm_indata;
    end
    assign tm_data = ram[tm_address];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        shadow[a] = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic model_reset();
        in_burst = 1'b0; burst_left = 0; denied = 0;
        exp_rvalid = 1'b0; exp_rdata = 8'h00; last_dgnt = 1'b0;
    endtask

    // Predicts this cycle's outputs from the current inputs, then advances to the next edge.
    task automatic model_step();
        bit dg, cg;
        logic [15:0] a;
        logic rw;
        logic [7:0] d;
        cg = !in_burst && cpu_req;
        dg = in_burst ? dma_req : (!cpu_req && dma_req);
        a = cpu_addr; rw = 1'b1; d = cpu_wdata;
        if (dg) begin a = dma_addr; rw = dma_rW; d = dma_wdata; end
        else if (cg) begin rw = cpu_rW; end
        check("cpu_rdy", 16'(cpu_rdy), 16'(!in_burst));
        check("dma_gnt", 16'(dma_gnt), 16'(dg));
        check("tm_address", tm_address, a);
        check("tm_rW", 16'(tm_rW), 16'(rw));
        check("tm_indata", 16'(tm_indata), 16'(d));
        check("cpu_rdata", 16'(cpu_rdata), 16'(shadow[a]));
        check("dma_rvalid", 16'(dma_rvalid), 16'(exp_rvalid));
        check("dma_rdata", 16'(dma_rdata), 16'(exp_rdata));
        obs_gnt = dma_gnt; obs_rdy = cpu_rdy; obs_rw = tm_rW;
        obs_rv = dma_rvalid; obs_rd = dma_rdata; obs_cpud = cpu_rdata;
        last_dgnt = dg;
        if (dg && dma_rW) begin exp_rvalid = 1'b1; exp_rdata = shadow[dma_addr]; end
        else exp_rvalid = 1'b0;
        if (!rw) shadow[a] = d;
        if (in_burst) begin
            if (dg) burst_left--;
            if (!dma_req || burst_left == 0) in_burst = 1'b0;
        end else if (dma_req && !dg && denied + 1 == MAX_WAIT) begin
            in_burst = 1'b1;
            burst_left = BURST;
        end
        denied = (!dma_req || dg) ? 0 : ((denied < 255) ? denied + 1 : 255);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk); #1;
    endtask

    initial begin
        cpu_req = 1'b1; cpu_rW = 1'b0; dma_req = 1'b1; dma_rW = 1'b0;
        #1;
        check("rst_tm_rW", 16'(tm_rW), 16'd1);
        check("rst_cpu_rdy", 16'(cpu_rdy), 16'd0);
        check("rst_dma_gnt", 16'(dma_gnt), 16'd0);
        check("rst_rvalid", 16'(dma_rvalid), 16'd0);
        check("rst_rdata", 16'(dma_rdata), 16'h00);
        for (int i = 0; i < 64; i++) preload(16'(i), 8'($urandom));
        preload(16'h1234, 8'h5A);
        preload(16'h0200, 8'h00);
        preload(16'h0300, 8'h11);
        preload(16'h0301, 8'h22);
        cpu_req = 1'b0; cpu_rW = 1'b1; dma_req = 1'b0; dma_rW = 1'b1;
        cpu_addr = 16'h1234;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // CPU-only reads of a preloaded byte
        cpu_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("t1_rdata", 16'(obs_cpud), 16'h5A);
            check("t1_rdy", 16'(obs_rdy), 16'd1);
            check("t1_gnt", 16'(obs_gnt), 16'd0);
        end

        // Idle-slot DMA write then read back
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_addr = 16'h0200; dma_rW = 1'b0; dma_wdata = 8'hAB;
        cycle();
        check("t2_wgnt", 16'(obs_gnt), 16'd1);
        check("t2_wrw", 16'(obs_rw), 16'd0);
        dma_rW = 1'b1;
        cycle();
        check("t2_rgnt", 16'(obs_gnt), 16'd1);
        check("t2_rrw", 16'(obs_rw), 16'd1);
        dma_req = 1'b0;
        cycle();
        check("t2_rv", 16'(obs_rv), 16'd1);
        check("t2_rd", 16'(obs_rd), 16'hAB);
        cycle();
        check("t2_rv_end", 16'(obs_rv), 16'd0);

        // Both requesting continuously: forced bursts every 12 cycles
        cpu_req = 1'b1; cpu_addr = 16'h0005;
        dma_req = 1'b1; dma_addr = 16'h0010; dma_rW = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bit b;
            b = (i >= 8 && i <= 11) || (i >= 20);
            cycle();
            check("t3_gnt", 16'(obs_gnt), 16'(b));
            check("t3_rdy", 16'(obs_rdy), 16'(!b));
        end
        dma_req = 1'b0;
        cycle();

        // Burst abandoned by DMA after two grants; wait count restarts from zero
        for (int i = 0; i < 24; i++) begin
            bit g, r;
            dma_req = !(i == 10 || i == 11);
            g = (i == 8 || i == 9 || i >= 20);
            r = !((i >= 8 && i <= 10) || i >= 20);
            cycle();
            check("t4_gnt", 16'(obs_gnt), 16'(g));
            check("t4_rdy", 16'(obs_rdy), 16'(r));
        end
        dma_req = 1'b0;
        cycle();

        // Reset during the second cycle of a write burst
        cpu_addr = 16'h1234; cpu_rW = 1'b1;
        dma_req = 1'b1; dma_addr = 16'h0300; dma_rW = 1'b0; dma_wdata = 8'h77;
        for (int i = 0; i < 9; i++) cycle();
        dma_addr = 16'h0301; dma_wdata = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        check("t5_tm_rW", 16'(tm_rW), 16'd1);
        check("t5_rdy", 16'(cpu_rdy), 16'd0);
        check("t5_gnt", 16'(dma_gnt), 16'd0);
        @(posedge clk); #1;
        check("t5_byte", 16'(ram[16'h0301]), 16'h22);
        check("t5_first", 16'(ram[16'h0300]), 16'h77);
        check("t5_rv", 16'(dma_rvalid), 16'd0);
        shadow[16'h0300] = 8'h77;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        #1;
        model_step();
        check("t5_cpu_mode_rdy", 16'(obs_rdy), 16'd1);
        check("t5_cpu_mode_gnt", 16'(obs_gnt), 16'd0);
        @(posedge clk); #1;

        // Random traffic over a preloaded window
        for (int i = 0; i < 1500; i++) begin
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_addr = 16'($urandom_range(0, 63));
            cpu_rW = 1'($urandom_range(0, 1));
            cpu_wdata = 8'($urandom);
            if (!dma_req || last_dgnt) begin
                dma_req = 1'($urandom_range(0, 1));
                dma_addr = 16'($urandom_range(0, 63));
                dma_rW = 1'($urandom_range(0, 1));
                dma_wdata = 8'($urandom);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
